// File: rtl/tcp_pkg.sv
// Shared TCP receive-path widths and the app-read controller state encoding.
package tcp_pkg;

  localparam int FLOWID_W         = 8;
  localparam int RX_PAYLOAD_PTR_W = 16;
  // One extra bit distinguishes a full buffer from an empty one.
  localparam int PW               = RX_PAYLOAD_PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_CALC    = 3'd3,
    ST_WR_HEAD = 3'd4,
    ST_RESP    = 3'd5
  } rx_app_rd_state_e;

endpackage

// File: rtl/rx_app_read_ctrl.sv
// App read controller: fetches a flow's head/tail pointers, grants min(len, avail), advances head.
// Optional macro RX_APP_READ_PEEK_EN adds app_rd_req_peek (read without consuming).
module rx_app_read_ctrl
  import tcp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic                app_rd_req_val,
  output logic                app_rd_req_rdy,
  input  logic [FLOWID_W-1:0] app_rd_req_flowid,
  input  logic [PW-1:0]       app_rd_req_len,
`ifdef RX_APP_READ_PEEK_EN
  input  logic                app_rd_req_peek,
`endif

  output logic                app_rd_resp_val,
  input  logic                app_rd_resp_rdy,
  output logic [FLOWID_W-1:0] app_rd_resp_flowid,
  output logic [PW-1:0]       app_rd_resp_ptr,
  output logic [PW-1:0]       app_rd_resp_len,

  output logic                head_ptr_rd_req_val,
  output logic [FLOWID_W-1:0] head_ptr_rd_req_addr,
  input  logic                head_ptr_rd_req_rdy,
  input  logic                head_ptr_rd_resp_val,
  input  logic [PW-1:0]       head_ptr_rd_resp_data,
  output logic                head_ptr_rd_resp_rdy,

  output logic                tail_ptr_rd_req_val,
  output logic [FLOWID_W-1:0] tail_ptr_rd_req_addr,
  input  logic                tail_ptr_rd_req_rdy,
  input  logic                tail_ptr_rd_resp_val,
  input  logic [PW-1:0]       tail_ptr_rd_resp_data,
  output logic                tail_ptr_rd_resp_rdy,

  output logic                head_ptr_wr_req_val,
  output logic [FLOWID_W-1:0] head_ptr_wr_req_addr,
  output logic [PW-1:0]       head_ptr_wr_req_data,
  input  logic                head_ptr_wr_req_rdy
);

  rx_app_rd_state_e    state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [PW-1:0]       req_len_q, req_len_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [PW-1:0]       grant_q, grant_d;
  logic [PW-1:0]       new_head_q, new_head_d;
  logic                hd_sent_q, hd_sent_d;
  logic                tl_sent_q, tl_sent_d;
  logic                hd_got_q, hd_got_d;
  logic                tl_got_q, tl_got_d;
  // Keeps req_rdy low for the first cycle after reset release.
  logic                out_en_q, out_en_d;
  logic                peek_q, peek_d;

  logic [PW-1:0]       avail;
  logic [PW-1:0]       grant_c;
  logic                skip_wr;

  // Modular subtraction handles wrap-around with no special case.
  always_comb begin
    avail   = tail_q - head_q;
    grant_c = (req_len_q < avail) ? req_len_q : avail;
    skip_wr = (grant_c == '0) || peek_q;
  end

  always_comb begin
    state_d    = state_q;
    flowid_d   = flowid_q;
    req_len_d  = req_len_q;
    head_d     = head_q;
    tail_d     = tail_q;
    grant_d    = grant_q;
    new_head_d = new_head_q;
    hd_sent_d  = hd_sent_q;
    tl_sent_d  = tl_sent_q;
    hd_got_d   = hd_got_q;
    tl_got_d   = tl_got_q;
    peek_d     = peek_q;
    out_en_d   = 1'b1;

    app_rd_req_rdy       = 1'b0;
    app_rd_resp_val      = 1'b0;
    head_ptr_rd_req_val  = 1'b0;
    tail_ptr_rd_req_val  = 1'b0;
    head_ptr_rd_resp_rdy = 1'b0;
    tail_ptr_rd_resp_rdy = 1'b0;
    head_ptr_wr_req_val  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        app_rd_req_rdy = out_en_q;
        if (out_en_q && app_rd_req_val) begin
          flowid_d  = app_rd_req_flowid;
          req_len_d = app_rd_req_len;
`ifdef RX_APP_READ_PEEK_EN
          peek_d    = app_rd_req_peek;
`else
          peek_d    = 1'b0;
`endif
          hd_sent_d = 1'b0;
          tl_sent_d = 1'b0;
          hd_got_d  = 1'b0;
          tl_got_d  = 1'b0;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        head_ptr_rd_req_val = !hd_sent_q;
        tail_ptr_rd_req_val = !tl_sent_q;
        if (head_ptr_rd_req_val && head_ptr_rd_req_rdy) hd_sent_d = 1'b1;
        if (tail_ptr_rd_req_val && tail_ptr_rd_req_rdy) tl_sent_d = 1'b1;
        if (hd_sent_d && tl_sent_d) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        head_ptr_rd_resp_rdy = !hd_got_q;
        tail_ptr_rd_resp_rdy = !tl_got_q;
        if (head_ptr_rd_resp_rdy && head_ptr_rd_resp_val) begin
          head_d   = head_ptr_rd_resp_data;
          hd_got_d = 1'b1;
        end
        if (tail_ptr_rd_resp_rdy && tail_ptr_rd_resp_val) begin
          tail_d   = tail_ptr_rd_resp_data;
          tl_got_d = 1'b1;
        end
        if (hd_got_d && tl_got_d) state_d = ST_CALC;
      end
      ST_CALC: begin
        grant_d    = grant_c;
        new_head_d = head_q + grant_c;
        state_d    = skip_wr ? ST_RESP : ST_WR_HEAD;
      end
      ST_WR_HEAD: begin
        head_ptr_wr_req_val = 1'b1;
        if (head_ptr_wr_req_rdy) state_d = ST_RESP;
      end
      ST_RESP: begin
        app_rd_resp_val = 1'b1;
        if (app_rd_resp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      flowid_q   <= '0;
      req_len_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      grant_q    <= '0;
      new_head_q <= '0;
      hd_sent_q  <= 1'b0;
      tl_sent_q  <= 1'b0;
      hd_got_q   <= 1'b0;
      tl_got_q   <= 1'b0;
      peek_q     <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flowid_q   <= flowid_d;
      req_len_q  <= req_len_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      grant_q    <= grant_d;
      new_head_q <= new_head_d;
      hd_sent_q  <= hd_sent_d;
      tl_sent_q  <= tl_sent_d;
      hd_got_q   <= hd_got_d;
      tl_got_q   <= tl_got_d;
      peek_q     <= peek_d;
      out_en_q   <= out_en_d;
    end
  end

  assign head_ptr_rd_req_addr = flowid_q;
  assign tail_ptr_rd_req_addr = flowid_q;
  assign head_ptr_wr_req_addr = flowid_q;
  assign head_ptr_wr_req_data = new_head_q;
  assign app_rd_resp_flowid   = flowid_q;
  assign app_rd_resp_ptr      = head_q;
  assign app_rd_resp_len      = grant_q;

endmodule

// File: tb/tb_rx_app_read_ctrl.sv
// Scoreboard bench for rx_app_read_ctrl: pointer-memory model with tunable back-pressure.
`timescale 1ns/1ps
module tb_rx_app_read_ctrl;
  import tcp_pkg::*;

  typedef struct packed { logic [FLOWID_W-1:0] fid; logic [PW-1:0] len; logic pk; } req_t;
  typedef struct packed { logic [FLOWID_W-1:0] fid; logic [PW-1:0] ptr; logic [PW-1:0] len; } rsp_t;
  typedef struct packed { logic [FLOWID_W-1:0] addr; logic [PW-1:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic                app_rd_req_val, app_rd_req_rdy, app_rd_req_peek;
  logic [FLOWID_W-1:0] app_rd_req_flowid;
  logic [PW-1:0]       app_rd_req_len;
  logic                app_rd_resp_val, app_rd_resp_rdy;
  logic [FLOWID_W-1:0] app_rd_resp_flowid;
  logic [PW-1:0]       app_rd_resp_ptr, app_rd_resp_len;
  logic                head_ptr_rd_req_val, head_ptr_rd_req_rdy, head_ptr_rd_resp_val, head_ptr_rd_resp_rdy;
  logic [FLOWID_W-1:0] head_ptr_rd_req_addr, tail_ptr_rd_req_addr, head_ptr_wr_req_addr;
  logic [PW-1:0]       head_ptr_rd_resp_data, tail_ptr_rd_resp_data, head_ptr_wr_req_data;
  logic                tail_ptr_rd_req_val, tail_ptr_rd_req_rdy, tail_ptr_rd_resp_val, tail_ptr_rd_resp_rdy;
  logic                head_ptr_wr_req_val, head_ptr_wr_req_rdy;

  rx_app_read_ctrl dut (
    .clk(clk), .rst(rst),
    .app_rd_req_val(app_rd_req_val), .app_rd_req_rdy(app_rd_req_rdy),
    .app_rd_req_flowid(app_rd_req_flowid), .app_rd_req_len(app_rd_req_len),
`ifdef RX_APP_READ_PEEK_EN
    .app_rd_req_peek(app_rd_req_peek),
`endif
    .app_rd_resp_val(app_rd_resp_val), .app_rd_resp_rdy(app_rd_resp_rdy),
    .app_rd_resp_flowid(app_rd_resp_flowid), .app_rd_resp_ptr(app_rd_resp_ptr),
    .app_rd_resp_len(app_rd_resp_len),
    .head_ptr_rd_req_val(head_ptr_rd_req_val), .head_ptr_rd_req_addr(head_ptr_rd_req_addr),
    .head_ptr_rd_req_rdy(head_ptr_rd_req_rdy), .head_ptr_rd_resp_val(head_ptr_rd_resp_val),
    .head_ptr_rd_resp_data(head_ptr_rd_resp_data), .head_ptr_rd_resp_rdy(head_ptr_rd_resp_rdy),
    .tail_ptr_rd_req_val(tail_ptr_rd_req_val), .tail_ptr_rd_req_addr(tail_ptr_rd_req_addr),
    .tail_ptr_rd_req_rdy(tail_ptr_rd_req_rdy), .tail_ptr_rd_resp_val(tail_ptr_rd_resp_val),
    .tail_ptr_rd_resp_data(tail_ptr_rd_resp_data), .tail_ptr_rd_resp_rdy(tail_ptr_rd_resp_rdy),
    .head_ptr_wr_req_val(head_ptr_wr_req_val), .head_ptr_wr_req_addr(head_ptr_wr_req_addr),
    .head_ptr_wr_req_data(head_ptr_wr_req_data), .head_ptr_wr_req_rdy(head_ptr_wr_req_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  req_t req_q[$];
  rsp_t exp_rsp[$];
  wr_t  exp_wr[$];
  logic [PW-1:0] head_mem [256];
  logic [PW-1:0] tail_mem [256];
  logic [PW-1:0] sh_head  [256];
  int tail_dly = 0, wr_dly = 0, rsp_dly = 0;
  int tail_cnt, wr_wait, rsp_wait;
  int cyc = 0, req_cyc = 0, last_lat = 0, rsp_cnt = 0, wr_cnt = 0, stab_cnt = 0;
  logic f_req, f_hreq, f_treq, f_hrsp, f_trsp, f_wr, f_rsp;
  logic [FLOWID_W-1:0] f_haddr, f_taddr;
  wr_t  f_w, wr_hold, wr_cur, wr_e;
  rsp_t rsp_hold, rsp_cur, rsp_e, last_rsp;
  logic rsp_held, wr_held;

  // Pointer memories, request driver and output checks, all evaluated on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      app_rd_req_val = 0; app_rd_req_flowid = '0; app_rd_req_len = '0; app_rd_req_peek = 0;
      app_rd_resp_rdy = 0; head_ptr_rd_req_rdy = 0; tail_ptr_rd_req_rdy = 0;
      head_ptr_rd_resp_val = 0; head_ptr_rd_resp_data = '0;
      tail_ptr_rd_resp_val = 0; tail_ptr_rd_resp_data = '0; head_ptr_wr_req_rdy = 0;
      {f_req, f_hreq, f_treq, f_hrsp, f_trsp, f_wr, f_rsp} = '0;
      tail_cnt = 0; wr_wait = 0; rsp_wait = 0; rsp_held = 0; wr_held = 0;
      req_q.delete();
    end else begin
      if (f_req) void'(req_q.pop_front());
      if (f_hrsp) head_ptr_rd_resp_val = 0;
      if (f_trsp) tail_ptr_rd_resp_val = 0;
      if (f_hreq) begin head_ptr_rd_resp_val = 1; head_ptr_rd_resp_data = head_mem[f_haddr]; end
      if (f_treq) begin tail_ptr_rd_resp_val = 1; tail_ptr_rd_resp_data = tail_mem[f_taddr]; end
      if (f_wr) head_mem[f_w.addr] = f_w.data;

      app_rd_req_val = (req_q.size() != 0);
      if (app_rd_req_val) begin
        app_rd_req_flowid = req_q[0].fid; app_rd_req_len = req_q[0].len; app_rd_req_peek = req_q[0].pk;
      end
      head_ptr_rd_req_rdy = 1;
      if (tail_ptr_rd_req_val) begin tail_ptr_rd_req_rdy = (tail_cnt >= tail_dly); tail_cnt++; end
      else begin tail_ptr_rd_req_rdy = 0; tail_cnt = 0; end
      if (head_ptr_wr_req_val) begin head_ptr_wr_req_rdy = (wr_wait >= wr_dly); wr_wait++; end
      else begin head_ptr_wr_req_rdy = 0; wr_wait = 0; end
      if (app_rd_resp_val) begin app_rd_resp_rdy = (rsp_wait >= rsp_dly); rsp_wait++; end
      else begin app_rd_resp_rdy = 0; rsp_wait = 0; end

      f_req  = app_rd_req_val && app_rd_req_rdy;
      if (f_req) req_cyc = cyc;
      f_hreq = head_ptr_rd_req_val && head_ptr_rd_req_rdy;  f_haddr = head_ptr_rd_req_addr;
      f_treq = tail_ptr_rd_req_val && tail_ptr_rd_req_rdy;  f_taddr = tail_ptr_rd_req_addr;
      f_hrsp = head_ptr_rd_resp_val && head_ptr_rd_resp_rdy;
      f_trsp = tail_ptr_rd_resp_val && tail_ptr_rd_resp_rdy;
      f_wr   = head_ptr_wr_req_val && head_ptr_wr_req_rdy;
      f_w    = {head_ptr_wr_req_addr, head_ptr_wr_req_data};
      f_rsp  = app_rd_resp_val && app_rd_resp_rdy;
      rsp_cur = {app_rd_resp_flowid, app_rd_resp_ptr, app_rd_resp_len};
      wr_cur  = f_w;

      if (f_wr) begin
        wr_cnt++; n_tests++;
        if (exp_wr.size() == 0) begin
          n_fail++; $display("FAIL head_write_unexpected got addr=%h data=%h expected none", f_w.addr, f_w.data);
        end else begin
          wr_e = exp_wr.pop_front();
          if (f_w !== wr_e) begin
            n_fail++; $display("FAIL head_write got addr=%h data=%h expected addr=%h data=%h", f_w.addr, f_w.data, wr_e.addr, wr_e.data);
          end
        end
      end
      if (f_rsp) begin
        rsp_cnt++; n_tests++; last_lat = cyc - req_cyc; last_rsp = rsp_cur;
        if (exp_rsp.size() == 0) begin
          n_fail++; $display("FAIL resp_unexpected got fid=%h ptr=%h len=%h", rsp_cur.fid, rsp_cur.ptr, rsp_cur.len);
        end else begin
          rsp_e = exp_rsp.pop_front();
          if (rsp_cur !== rsp_e) begin
            n_fail++; $display("FAIL resp got fid=%h ptr=%h len=%h expected fid=%h ptr=%h len=%h",
              rsp_cur.fid, rsp_cur.ptr, rsp_cur.len, rsp_e.fid, rsp_e.ptr, rsp_e.len);
          end
        end
      end
      if (app_rd_resp_val && !app_rd_resp_rdy) begin
        if (rsp_held) begin
          n_tests++; stab_cnt++;
          if (rsp_cur !== rsp_hold || app_rd_req_rdy !== 1'b0) begin
            n_fail++; $display("FAIL resp_stall_stable got %h rdy=%b expected %h rdy=0", rsp_cur, app_rd_req_rdy, rsp_hold);
          end
        end
        rsp_hold = rsp_cur; rsp_held = 1;
      end else rsp_held = 0;
      if (head_ptr_wr_req_val && !head_ptr_wr_req_rdy) begin
        if (wr_held) begin
          n_tests++; stab_cnt++;
          if (wr_cur !== wr_hold) begin
            n_fail++; $display("FAIL wr_stall_stable got %h expected %h", wr_cur, wr_hold);
          end
        end
        wr_hold = wr_cur; wr_held = 1;
      end else wr_held = 0;
    end
  end

  task automatic set_ptrs(input logic [FLOWID_W-1:0] fid, input logic [PW-1:0] h, input logic [PW-1:0] t);
    head_mem[fid] = h; tail_mem[fid] = t; sh_head[fid] = h;
  endtask

  task automatic push_req(input logic [FLOWID_W-1:0] fid, input logic [PW-1:0] len, input logic pk);
    logic [PW-1:0] avail, g;
    avail = tail_mem[fid] - sh_head[fid];
    g = (len < avail) ? len : avail;
    exp_rsp.push_back({fid, sh_head[fid], g});
    if (g != '0 && !pk) begin
      exp_wr.push_back({fid, sh_head[fid] + g});
      sh_head[fid] = sh_head[fid] + g;
    end
    req_q.push_back({fid, len, pk});
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (rsp_cnt < target && t < 400) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (rsp_cnt < target || exp_rsp.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL %s_done got resp=%0d pend_rsp=%0d pend_wr=%0d expected resp=%0d pend 0", name, rsp_cnt, exp_rsp.size(), exp_wr.size(), target);
      exp_rsp.delete(); exp_wr.delete();
    end
  endtask

  task automatic check_last(input string name, input logic [PW-1:0] ptr, input logic [PW-1:0] len,
                            input logic [FLOWID_W-1:0] fid, input logic [PW-1:0] head, input int lat);
    n_tests++;
    if (last_rsp.ptr !== ptr || last_rsp.len !== len || head_mem[fid] !== head || (lat >= 0 && last_lat != lat)) begin
      n_fail++;
      $display("FAIL %s got ptr=%h len=%h head=%h lat=%0d expected ptr=%h len=%h head=%h lat=%0d",
        name, last_rsp.ptr, last_rsp.len, head_mem[fid], last_lat, ptr, len, head, lat);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({app_rd_req_rdy, app_rd_resp_val, app_rd_resp_flowid, app_rd_resp_ptr, app_rd_resp_len,
         head_ptr_rd_req_val, head_ptr_rd_req_addr, head_ptr_rd_resp_rdy, tail_ptr_rd_req_val,
         tail_ptr_rd_req_addr, tail_ptr_rd_resp_rdy, head_ptr_wr_req_val, head_ptr_wr_req_addr,
         head_ptr_wr_req_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero output expected all 0");
    end
    @(negedge clk); rst = 1; #1;
    n_tests++;
    if (app_rd_req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_release_rdy got %b expected 0", app_rd_req_rdy); end
    @(negedge clk); #1;
    n_tests++;
    if (app_rd_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after got %b expected 1", app_rd_req_rdy); end
  endtask

  task automatic test_normal();
    set_ptrs(8'd3, 17'h00100, 17'h00180);
    push_req(8'd3, 17'h40, 0);
    wait_done(rsp_cnt + 1, "normal");
    check_last("normal", 17'h00100, 17'h40, 8'd3, 17'h00140, 5);
  endtask

  task automatic test_wrap();
    set_ptrs(8'd5, 17'h1FFF0, 17'h00010);
    push_req(8'd5, 17'h100, 0);
    wait_done(rsp_cnt + 1, "wrap");
    check_last("wrap", 17'h1FFF0, 17'h20, 8'd5, 17'h00010, 5);
  endtask

  task automatic test_empty();
    int w0 = wr_cnt;
    set_ptrs(8'd7, 17'h00200, 17'h00200);
    push_req(8'd7, 17'h10, 0);
    wait_done(rsp_cnt + 1, "empty");
    check_last("empty", 17'h00200, 17'h0, 8'd7, 17'h00200, 4);
    set_ptrs(8'd8, 17'h00000, 17'h00050);
    push_req(8'd8, 17'h0, 0);
    wait_done(rsp_cnt + 1, "zero_len");
    check_last("zero_len", 17'h00000, 17'h0, 8'd8, 17'h00000, 4);
    n_tests++;
    if (wr_cnt != w0) begin n_fail++; $display("FAIL empty_no_write got %0d writes expected 0", wr_cnt - w0); end
  endtask

  task automatic test_backpressure();
    int w0 = wr_cnt, s0 = stab_cnt;
    tail_dly = 3; wr_dly = 4; rsp_dly = 10;
    set_ptrs(8'd9, 17'h00300, 17'h00380);
    push_req(8'd9, 17'h20, 0);
    wait_done(rsp_cnt + 1, "backpressure");
    check_last("backpressure", 17'h00300, 17'h20, 8'd9, 17'h00320, -1);
    n_tests++;
    if (wr_cnt - w0 != 1 || stab_cnt - s0 < 10) begin
      n_fail++; $display("FAIL backpressure_counts got writes=%0d stalls=%0d expected writes=1 stalls>=10", wr_cnt - w0, stab_cnt - s0);
    end
    tail_dly = 0; wr_dly = 0; rsp_dly = 0;
  endtask

  task automatic test_wr_reset();
    int w0 = wr_cnt, r0 = rsp_cnt, t = 0;
    wr_dly = 1000;
    set_ptrs(8'd10, 17'h00000, 17'h00040);
    push_req(8'd10, 17'h10, 0);
    while (head_ptr_wr_req_val !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_tests++;
    if (head_ptr_wr_req_val !== 1'b1) begin n_fail++; $display("FAIL wr_reset_reach got 0 expected wr val 1"); end
    @(posedge clk); #2 rst = 0; #1;
    n_tests++;
    if (head_ptr_wr_req_val !== 1'b0 || head_ptr_wr_req_data !== '0 || app_rd_req_rdy !== 1'b0) begin
      n_fail++; $display("FAIL wr_reset_drop got val=%b data=%h rdy=%b expected 0", head_ptr_wr_req_val, head_ptr_wr_req_data, app_rd_req_rdy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1;
    exp_rsp.delete(); exp_wr.delete(); sh_head[10] = head_mem[10];
    wr_dly = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (wr_cnt != w0 || rsp_cnt != r0 || head_mem[10] !== 17'h0) begin
      n_fail++; $display("FAIL wr_reset_nowrite got writes=%0d resps=%0d head=%h expected 0 0 0", wr_cnt - w0, rsp_cnt - r0, head_mem[10]);
    end
    push_req(8'd10, 17'h10, 0);
    wait_done(rsp_cnt + 1, "after_reset");
    check_last("after_reset", 17'h00000, 17'h10, 8'd10, 17'h00010, 5);
  endtask

  task automatic test_back_to_back();
    set_ptrs(8'd12, 17'h00000, 17'h00030);
    push_req(8'd12, 17'h10, 0);
    push_req(8'd12, 17'h10, 0);
    push_req(8'd12, 17'h20, 0);
    push_req(8'd12, 17'h20, 0);
    wait_done(rsp_cnt + 4, "back_to_back");
    check_last("back_to_back", 17'h00030, 17'h0, 8'd12, 17'h00030, -1);
  endtask

  task automatic test_random();
    for (int f = 20; f < 28; f++)
      set_ptrs(8'(f), 17'($urandom), 17'($urandom));
    for (int i = 0; i < 12; i++) begin
      tail_dly = $urandom_range(0, 3); wr_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(0, 3);
      push_req(8'($urandom_range(20, 27)), 17'($urandom_range(0, 17'h1FFFF)), 0);
      wait_done(rsp_cnt + 1, "random");
    end
    tail_dly = 0; wr_dly = 0; rsp_dly = 0;
  endtask

`ifdef RX_APP_READ_PEEK_EN
  task automatic test_peek();
    int w0 = wr_cnt;
    set_ptrs(8'd30, 17'h00000, 17'h00080);
    push_req(8'd30, 17'h80, 1);
    wait_done(rsp_cnt + 1, "peek");
    check_last("peek", 17'h00000, 17'h80, 8'd30, 17'h00000, 4);
    n_tests++;
    if (wr_cnt != w0) begin n_fail++; $display("FAIL peek_no_write got %0d writes expected 0", wr_cnt - w0); end
    push_req(8'd30, 17'h80, 0);
    wait_done(rsp_cnt + 1, "peek_repeat");
    check_last("peek_repeat", 17'h00000, 17'h80, 8'd30, 17'h00080, 5);
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_wrap();
    test_empty();
    test_backpressure();
    test_wr_reset();
    test_back_to_back();
    test_random();
`ifdef RX_APP_READ_PEEK_EN
    test_peek();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_app_read_ctrl.md
RX_APP_READ_CTRL -- requirements
Module: rx_app_read_ctrl

Interface
REQ-001 SHALL have no parameters; all widths come from tcp_pkg (FLOWID_W, RX_PAYLOAD_PTR_W); pointer width PW = RX_PAYLOAD_PTR_W+1.
REQ-002 SHALL have clk  in  1  sole clock; rising-edge.
REQ-003 SHALL have rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have app_rd_req_val/rdy  in/out  1 each  app read request handshake.
REQ-005 SHALL have app_rd_req_flowid  in  FLOWID_W  and  app_rd_req_len  in  PW  (bytes wanted).
REQ-006 SHALL have app_rd_resp_val  out  1, app_rd_resp_rdy  in  1, app_rd_resp_flowid  out  FLOWID_W, app_rd_resp_ptr  out  PW (start ptr), app_rd_resp_len  out  PW (granted bytes).
REQ-007 SHALL have head_ptr_rd_req_val/addr/rdy  out/out FLOWID_W/in, head_ptr_rd_resp_val/data/rdy  in/in PW/out.
REQ-008 SHALL have tail_ptr_rd_req_val/addr/rdy and tail_ptr_rd_resp_val/data/rdy with the same widths and directions as the head read ports.
REQ-009 SHALL have head_ptr_wr_req_val  out  1, head_ptr_wr_req_addr  out  FLOWID_W, head_ptr_wr_req_data  out  PW, head_ptr_wr_req_rdy  in  1.

Function
REQ-010 SHALL implement FSM IDLE -> RD_REQ -> RD_RESP -> CALC -> WR_HEAD -> RESP -> IDLE; CALC goes directly to RESP when the grant is 0.
REQ-011 SHALL assert app_rd_req_rdy only in IDLE; on handshake, register flowid and len, then go to RD_REQ.
REQ-012 In RD_REQ SHALL drive both read-request vals with the registered flowid; track each accept in a sent flag; a port deasserts val after its accept; leave RD_REQ when both flags are set.
REQ-013 In RD_RESP SHALL assert both resp_rdy until each response is captured (per-port got flags); responses may arrive in either order or the same cycle; leave when both are captured.
REQ-014 CALC SHALL compute avail = (tail - head) mod 2^PW, grant = min(req_len, avail) and new_head = (head + grant) mod 2^PW, and register all three.
REQ-015 WR_HEAD SHALL hold head_ptr_wr_req_val and stable addr/data until rdy is high; the write is never dropped.
REQ-016 RESP SHALL hold app_rd_resp_val with ptr = head read, len = grant and flowid until app_rd_resp_rdy is high; no new request is accepted before that.
REQ-017 SHALL have a minimum latency of 5 cycles from the req handshake to resp_val with zero stalls (4 cycles if grant = 0).
REQ-018 Empty buffer (head == tail) SHALL give grant 0 with no head write; req_len = 0 SHALL also give grant 0.
REQ-019 Wrap-around SHALL be handled purely by modular PW-bit arithmetic; no special case.

Reset
REQ-020 On rst = 0, SHALL go to IDLE immediately and clear all flags and registered fields.
REQ-021 During reset SHALL drive every val and rdy output to 0 (app_rd_req_rdy becomes 1 one cycle after release) and all data outputs to 0.
REQ-022 Reset mid-operation SHALL abandon the transaction; no partial head write completes after rst falls.

Configuration
REQ-023 Macro RX_APP_READ_PEEK_EN: when defined, SHALL add input app_rd_req_peek (1 bit), registered with the request.
REQ-024 With the macro defined, a peek request SHALL follow CALC -> RESP with no head write; the response is identical to a non-peek request.
REQ-025 With the macro undefined, the port SHALL be absent and every request with grant > 0 SHALL write the head.

Structure
REQ-026 The FSM state enum (rx_app_rd_state_e) SHALL live in tcp_pkg; PW is derived there as RX_PAYLOAD_PTR_W+1.
REQ-027 SHALL be a single module with no submodules; the min/modular arithmetic is inline.

Verification (RX_PAYLOAD_PTR_W = 16, PW = 17)
REQ-028 Normal read: head 0x00100, tail 0x00180, req 0x40 -> resp ptr 0x00100, len 0x40; head write 0x00140.
REQ-029 Wrap-around: head 0x1FFF0, tail 0x00010, req 0x100 -> len 0x20, ptr 0x1FFF0; head write 0x00010.
REQ-030 Empty: head = tail = 0x00200, req 0x10 -> len 0; no head_ptr_wr_req_val in any cycle.
REQ-031 Back-pressure: tail read accepted 3 cycles after head; head_ptr_wr_req_rdy low 4 cycles; resp_rdy low 10 cycles -> outputs stable throughout, req_rdy stays 0, exactly one head write.
REQ-032 Reset during WR_HEAD: rst low 2 cycles -> wr val drops that cycle, no write; the next request completes normally.
REQ-033 Peek (RX_APP_READ_PEEK_EN defined): head 0x00000, tail 0x00080, req 0x80, peek = 1 -> len 0x80, no head write; a repeated non-peek request returns the same ptr.
